// File: rtl/dct_cos_seq.sv
// dct_cos_seq: streams the N*N separable DCT cosine products C(k1,n1)*C(k2,n2)
// in raster order through a 3-stage pipeline with valid/ready output handshake.
module dct_cos_seq #(
   parameter int N = 8,
   parameter int W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [$clog2(N)-1:0] k1,
   input  logic [$clog2(N)-1:0] k2,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*W-1:0]       cos_term,
   output logic [$clog2(N)-1:0] out_n1,
   output logic [$clog2(N)-1:0] out_n2,
   output logic                 out_last,
   output logic                 busy
);
   localparam int L  = $clog2(N);
   localparam int MW = L + 2;                  // m = ((2n+1)k) mod 4N needs L+2 bits
   localparam logic [2*L-1:0] LAST_IDX = '1;   // N*N-1, N is a power of two
   localparam logic [MW:0] C_N  = (MW+1)'(N);
   localparam logic [MW:0] C_2N = (MW+1)'(2*N);
   localparam logic [MW:0] C_3N = (MW+1)'(3*N);
   localparam logic [MW:0] C_4N = (MW+1)'(4*N);

   // Quarter-wave table T[0..N], built at elaboration with a Taylor series; T[N] stays 0
   function automatic logic [(N+1)*W-1:0] f_build_table();
      logic [(N+1)*W-1:0] tbl;
      real x, term, sum, amp;
      int  v;
      tbl = '0;
      amp = $itor((2 ** (W-1)) - 1);
      for (int unsigned i = 0; i < N; i++) begin
         x    = $itor(i) * 3.14159265358979323846 / $itor(2 * N);
         term = 1.0;
         sum  = 1.0;
         for (int unsigned k = 1; k <= 12; k++) begin
            term = -term * x * x / $itor((2*k-1) * (2*k));
            sum  = sum + term;
         end
         v = $rtoi(sum * amp + 0.5);
         tbl[i*W +: W] = v[W-1:0];
      end
      return tbl;
   endfunction

   localparam logic [(N+1)*W-1:0] COS_TBL = f_build_table();

   // Map a full-period phase index onto the quarter-wave table with sign
   function automatic logic signed [W-1:0] f_coef(input logic [MW-1:0] m);
      logic [MW:0]           mx, idx;
      logic                  neg;
      logic signed [W-1:0]   t;
      mx = {1'b0, m};
      if (mx <= C_N) begin
         idx = mx;          neg = 1'b0;
      end else if (mx < C_2N) begin
         idx = C_2N - mx;   neg = 1'b1;
      end else if (mx <= C_3N) begin
         idx = mx - C_2N;   neg = 1'b1;
      end else begin
         idx = C_4N - mx;   neg = 1'b0;
      end
      t = '0;
      for (int unsigned i = 0; i <= N; i++)
         if (idx == (MW+1)'(i)) t = COS_TBL[i*W +: W];
      return neg ? -t : t;
   endfunction

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} t_state;

   t_state               r_state, w_state_nx;
   logic [2*L-1:0]       r_cnt;
   logic [L-1:0]         r_k1, r_k2;
   // stage 1: indices and phase
   logic                 r_v1, r_last1;
   logic [MW-1:0]        r_ma, r_mb;
   logic [L-1:0]         r_n1_1, r_n2_1;
   // stage 2: signed coefficients
   logic                 r_v2, r_last2;
   logic signed [W-1:0]  r_ca, r_cb;
   logic [L-1:0]         r_n1_2, r_n2_2;
   // stage 3: product / output
   logic                 r_v3, r_last3;
   logic [2*W-1:0]       r_prod;
   logic [L-1:0]         r_n1_3, r_n2_3;

   logic                 w_accept, w_adv, w_issue, w_last_idx;
   logic [2*L-1:0]       w_idx;
   logic [L-1:0]         w_ka, w_kb, w_n1, w_n2;
   logic [MW-1:0]        w_ma, w_mb;

   assign w_accept   = start_valid & (r_state == S_IDLE);
   assign w_adv      = ~(r_v3 & ~out_ready);
   assign w_issue    = w_adv & (w_accept | (r_state == S_RUN));
   // the accept edge already issues index 0, using the k inputs directly
   assign w_idx      = w_accept ? '0 : r_cnt;
   assign w_ka       = w_accept ? k1 : r_k1;
   assign w_kb       = w_accept ? k2 : r_k2;
   assign w_n1       = w_idx[2*L-1:L];
   assign w_n2       = w_idx[L-1:0];
   assign w_last_idx = (w_idx == LAST_IDX);
   assign w_ma       = MW'({w_n1, 1'b1}) * MW'(w_ka);
   assign w_mb       = MW'({w_n2, 1'b1}) * MW'(w_kb);

   assign out_valid = r_v3;
   assign cos_term  = r_prod;
   assign out_n1    = r_n1_3;
   assign out_n2    = r_n2_3;
   assign out_last  = r_v3 & r_last3;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      w_state_nx  = r_state;
      start_ready = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) w_state_nx = S_RUN;
         end
         S_RUN: begin
            if (abort)                        w_state_nx = S_IDLE;
            else if (w_issue && w_last_idx)   w_state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                             w_state_nx = S_IDLE;
            else if (r_v3 && out_ready && r_last3) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Issue counter and frequency indices captured on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_k1  <= '0;
         r_k2  <= '0;
      end else begin
         if (w_issue) r_cnt <= w_idx + 1'b1;
         if (w_accept) begin
            r_k1 <= k1;
            r_k2 <= k2;
         end
      end
   end

   // Pipeline: all stages move together; abort outside IDLE empties them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0; r_last1 <= 1'b0; r_ma <= '0; r_mb <= '0; r_n1_1 <= '0; r_n2_1 <= '0;
         r_v2 <= 1'b0; r_last2 <= 1'b0; r_ca <= '0; r_cb <= '0; r_n1_2 <= '0; r_n2_2 <= '0;
         r_v3 <= 1'b0; r_last3 <= 1'b0; r_prod <= '0; r_n1_3 <= '0; r_n2_3 <= '0;
      end else if (abort && (r_state != S_IDLE)) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (w_adv) begin
         r_v1    <= w_issue;
         r_last1 <= w_last_idx;
         r_ma    <= w_ma;
         r_mb    <= w_mb;
         r_n1_1  <= w_n1;
         r_n2_1  <= w_n2;
         r_v2    <= r_v1;
         r_last2 <= r_last1;
         r_ca    <= f_coef(r_ma);
         r_cb    <= f_coef(r_mb);
         r_n1_2  <= r_n1_1;
         r_n2_2  <= r_n2_1;
         r_v3    <= r_v2;
         r_last3 <= r_last2;
         r_prod  <= {{W{r_ca[W-1]}}, r_ca} * {{W{r_cb[W-1]}}, r_cb};
         r_n1_3  <= r_n1_2;
         r_n2_3  <= r_n2_2;
      end
   end
endmodule

// File: tb/tb_dct_cos_seq.sv
// tb_dct_cos_seq: randomized checks of dct_cos_seq against a cosine reference model.
module tb_dct_cos_seq;
   localparam int  N   = 8;
   localparam int  W   = 16;
   localparam int  L   = 3;
   localparam int  NN  = N * N;
   localparam real PI  = 3.14159265358979323846;
   localparam real AMP = 32767.0;
   localparam real LSB = 32768.0;

   logic           clk = 1'b0;
   logic           rst, start_valid, start_ready, abort;
   logic           out_valid, out_ready, out_last, busy;
   logic [L-1:0]   k1, k2, out_n1, out_n2;
   logic [2*W-1:0] cos_term;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2*W-1:0] got_term[$];
   int             got_n1[$], got_n2[$];
   bit             got_last[$];
   int  d_ntr, d_lat, d_first, d_stall_bad, d_sr_seen, d_timeout;
   bit  d_ab_ov, d_ab_busy, d_ab_last;

   dct_cos_seq #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .k1(k1), .k2(k2), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
      .cos_term(cos_term), .out_n1(out_n1), .out_n2(out_n2), .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // reference 1D coefficient: rounded cosine of the reduced phase
   function automatic int coef(input int k, input int n);
      int  m;
      real c;
      m = ((2*n + 1) * k) % (4*N);
      c = $cos($itor(m) * PI / $itor(2*N)) * AMP;
      return (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
   endfunction

   function automatic logic [2*W-1:0] exp_term(input int ka, input int kb, input int n1, input int n2);
      longint p;
      p = longint'(coef(ka, n1)) * longint'(coef(kb, n2));
      return p[2*W-1:0];
   endfunction

   // drives one request and records every transfer plus handshake observations
   task automatic drive_seq(input int k1v, input int k2v, input bit rnd_ready,
                            input int abort_at, input bit hold_start);
      int             cyc;
      bit             st_pend;
      logic [2*W-1:0] st_term;
      logic [L-1:0]   st_n1, st_n2;
      logic           st_last;
      got_term.delete(); got_n1.delete(); got_n2.delete(); got_last.delete();
      d_ntr = 0; d_lat = -1; d_first = -1; d_stall_bad = 0; d_sr_seen = 0; d_timeout = 0;
      d_ab_ov = 0; d_ab_busy = 0; d_ab_last = 0;
      st_pend = 0; st_term = '0; st_n1 = '0; st_n2 = '0; st_last = 0;
      @(negedge clk);
      start_valid = 1'b1;
      k1 = k1v[L-1:0];
      k2 = k2v[L-1:0];
      cyc = 0;
      while (!start_ready) begin
         @(negedge clk);
         cyc++;
         if (cyc > 200) begin
            d_timeout = 1; start_valid = 1'b0; return;
         end
      end
      @(negedge clk);
      if (!hold_start) start_valid = 1'b0;
      k1 = L'($urandom);
      k2 = L'($urandom);
      for (int c = 1; c <= 3000; c++) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (start_ready) d_sr_seen++;
         if (out_valid && d_first < 0) d_first = c;
         if (st_pend && (!out_valid || cos_term !== st_term || out_n1 !== st_n1 ||
                         out_n2 !== st_n2 || out_last !== st_last)) d_stall_bad++;
         st_pend = 0;
         if (out_valid && out_ready) begin
            got_term.push_back(cos_term);
            got_n1.push_back(int'(out_n1));
            got_n2.push_back(int'(out_n2));
            got_last.push_back(out_last);
            d_ntr++;
            if (out_last) begin
               d_lat = c; start_valid = 1'b0; return;
            end
            if (abort_at != 0 && d_ntr == abort_at) begin
               abort = 1'b1;
               @(negedge clk);
               d_ab_ov = out_valid; d_ab_busy = busy; d_ab_last = out_last;
               abort = 1'b0; start_valid = 1'b0;
               return;
            end
         end else if (out_valid) begin
            st_pend = 1; st_term = cos_term; st_n1 = out_n1; st_n2 = out_n2; st_last = out_last;
         end
         @(negedge clk);
      end
      d_timeout = 1;
      start_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; k1 = '0; k2 = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({start_ready, busy, out_valid, out_last} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl got={rdy,busy,ov,last}=%b exp=1000", {start_ready, busy, out_valid, out_last});
      end
      n_tests++;
      if ({cos_term, out_n1, out_n2} !== '0) begin
         n_fail++;
         $display("FAIL reset_data got term=%0h n1=%0d n2=%0d exp all 0", cos_term, out_n1, out_n2);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_dc();
      drive_seq(0, 0, 1'b0, 0, 1'b0);
      n_tests++;
      if (d_ntr != NN || d_timeout != 0) begin
         n_fail++; $display("FAIL dc_count got=%0d timeout=%0d exp=%0d", d_ntr, d_timeout, NN);
      end
      n_tests++;
      if (d_first != 3) begin
         n_fail++; $display("FAIL dc_first_valid got=%0d exp=3", d_first);
      end
      n_tests++;
      if (d_lat != NN + 2) begin
         n_fail++; $display("FAIL dc_latency got=%0d exp=%0d", d_lat, NN + 2);
      end
      for (int i = 0; i < d_ntr; i++) begin
         n_tests++;
         if (got_term[i] !== 32'd1073676289 || got_n1[i] != i / N || got_n2[i] != i % N ||
             got_last[i] != (i == NN - 1)) begin
            n_fail++;
            $display("FAIL dc_term[%0d] got=%0d n1=%0d n2=%0d last=%0b exp=1073676289 n1=%0d n2=%0d last=%0b",
                     i, got_term[i], got_n1[i], got_n2[i], got_last[i], i / N, i % N, i == NN - 1);
         end
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || start_ready !== 1'b1) begin
         n_fail++; $display("FAIL dc_idle got busy=%b rdy=%b exp busy=0 rdy=1", busy, start_ready);
      end
   endtask

   task automatic test_k04();
      logic [2*W-1:0] pos_v, neg_v;
      pos_v = 32'd759211390;
      neg_v = -pos_v;
      drive_seq(0, 4, 1'b0, 0, 1'b0);
      n_tests++;
      if (d_ntr < 2 || got_term[0] !== pos_v) begin
         n_fail++; $display("FAIL k04_n2_0 got=%0d exp=759211390", (d_ntr > 0) ? $signed(got_term[0]) : 0);
      end
      n_tests++;
      if (d_ntr < 2 || got_term[1] !== neg_v) begin
         n_fail++; $display("FAIL k04_n2_1 got=%0d exp=-759211390", (d_ntr > 1) ? $signed(got_term[1]) : 0);
      end
      for (int i = 0; i < d_ntr; i++) begin
         n_tests++;
         if (got_term[i] !== exp_term(0, 4, i / N, i % N)) begin
            n_fail++;
            $display("FAIL k04_term[%0d] got=%0d exp=%0d", i, $signed(got_term[i]), $signed(exp_term(0, 4, i / N, i % N)));
         end
      end
   endtask

   task automatic test_stall_77();
      real f, diff;
      drive_seq(7, 7, 1'b1, 0, 1'b0);
      n_tests++;
      if (d_ntr != NN || d_timeout != 0) begin
         n_fail++; $display("FAIL stall_count got=%0d exp=%0d", d_ntr, NN);
      end
      n_tests++;
      if (d_stall_bad != 0) begin
         n_fail++; $display("FAIL stall_hold got=%0d unstable stalls exp=0", d_stall_bad);
      end
      for (int i = 0; i < d_ntr; i++) begin
         f = $cos($itor((2*(i/N) + 1) * 7) * PI / $itor(2*N)) *
             $cos($itor((2*(i%N) + 1) * 7) * PI / $itor(2*N)) * AMP * AMP;
         diff = $itor($signed(got_term[i])) - f;
         n_tests++;
         if (got_term[i] !== exp_term(7, 7, i / N, i % N) || got_n1[i] != i / N || got_n2[i] != i % N ||
             diff > 2.0 * LSB || diff < -2.0 * LSB) begin
            n_fail++;
            $display("FAIL stall_term[%0d] got=%0d n1=%0d n2=%0d exp=%0d n1=%0d n2=%0d", i, $signed(got_term[i]),
                     got_n1[i], got_n2[i], $signed(exp_term(7, 7, i / N, i % N)), i / N, i % N);
         end
      end
   endtask

   task automatic test_abort();
      int  ka, kb, lastcnt;
      ka = $urandom_range(0, N - 1);
      kb = $urandom_range(0, N - 1);
      drive_seq(ka, kb, 1'b0, 10, 1'b0);
      lastcnt = 0;
      foreach (got_last[i]) if (got_last[i]) lastcnt++;
      n_tests++;
      if (d_ntr != 10) begin
         n_fail++; $display("FAIL abort_count got=%0d exp=10", d_ntr);
      end
      n_tests++;
      if ({d_ab_ov, d_ab_busy, d_ab_last} != 3'b000 || lastcnt != 0) begin
         n_fail++;
         $display("FAIL abort_state got ov=%0b busy=%0b last=%0b lasts=%0d exp all 0", d_ab_ov, d_ab_busy, d_ab_last, lastcnt);
      end
      ka = $urandom_range(0, N - 1);
      kb = $urandom_range(0, N - 1);
      drive_seq(ka, kb, 1'b0, 0, 1'b0);
      n_tests++;
      if (d_ntr != NN || d_lat != NN + 2) begin
         n_fail++; $display("FAIL abort_next got=%0d lat=%0d exp=%0d lat=%0d", d_ntr, d_lat, NN, NN + 2);
      end
      for (int i = 0; i < d_ntr; i++) begin
         n_tests++;
         if (got_term[i] !== exp_term(ka, kb, i / N, i % N) || got_last[i] != (i == NN - 1)) begin
            n_fail++;
            $display("FAIL abort_next_term[%0d] got=%0d exp=%0d", i, $signed(got_term[i]), $signed(exp_term(ka, kb, i / N, i % N)));
         end
      end
   endtask

   task automatic test_hold_start();
      int ka, kb;
      ka = $urandom_range(0, N - 1);
      kb = $urandom_range(0, N - 1);
      drive_seq(ka, kb, 1'b0, 0, 1'b1);
      n_tests++;
      if (d_sr_seen != 0 || d_ntr != NN) begin
         n_fail++; $display("FAIL hold_single_accept got rdy_cycles=%0d terms=%0d exp 0 and %0d", d_sr_seen, d_ntr, NN);
      end
      @(negedge clk);
      n_tests++;
      if (start_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_ready_after_last got=%b exp=1", start_ready);
      end
   endtask

   task automatic test_rst_mid();
      int bad;
      @(negedge clk);
      start_valid = 1'b1; k1 = 3'd3; k2 = 3'd5; out_ready = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (20) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_running got busy=%b ov=%b exp 1 1", busy, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({start_ready, busy, out_valid, out_last} !== 4'b1000 || {cos_term, out_n1, out_n2} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async got={rdy,busy,ov,last}=%b term=%0h n1=%0d n2=%0d exp 1000 and 0",
                  {start_ready, busy, out_valid, out_last}, cos_term, out_n1, out_n2);
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL rstmid_after_release got=%0d active cycles exp=0", bad);
      end
   endtask

   task automatic test_random();
      int ka, kb;
      for (int r = 0; r < 4; r++) begin
         ka = $urandom_range(0, N - 1);
         kb = $urandom_range(0, N - 1);
         drive_seq(ka, kb, 1'b1, 0, 1'b0);
         n_tests++;
         if (d_ntr != NN || d_stall_bad != 0) begin
            n_fail++; $display("FAIL rand_seq[%0d] got terms=%0d stall_bad=%0d exp %0d 0", r, d_ntr, d_stall_bad, NN);
         end
         for (int i = 0; i < d_ntr; i++) begin
            n_tests++;
            if (got_term[i] !== exp_term(ka, kb, i / N, i % N) || got_n1[i] != i / N ||
                got_n2[i] != i % N || got_last[i] != (i == NN - 1)) begin
               n_fail++;
               $display("FAIL rand_term[%0d][%0d] k=%0d,%0d got=%0d exp=%0d", r, i, ka, kb,
                        $signed(got_term[i]), $signed(exp_term(ka, kb, i / N, i % N)));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_dc();
      test_k04();
      test_stall_77();
      test_abort();
      test_hold_start();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
